// File: rtl/sensor_event_queue.sv
// Sensor event queue: rising-edge capture of five threshold flags, round-robin into a FWFT FIFO; SENSOR_EVT_OVF_CNT_EN enables the lost-event counter.
// Latency: flag high at edge k -> pending after k -> head visible after k+1. One push and one pop per cycle.
// Backpressure: a full FIFO stops grants; pending sensors hold, and a repeat edge on a held sensor is counted as a loss.
`timescale 1ns/1ps
module sensor_event_queue #(
    parameter int DEPTH     = 8,
    parameter int IRQ_LEVEL = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     temp_thrhold_reached,
    input  logic                     humidity_thrhold_reached,
    input  logic                     dew_thrhold_reached,
    input  logic                     moisture_thrhold_reached,
    input  logic                     water_lvl_thrhold_reached,
    input  logic [15:0]              temp_data_out,
    input  logic [15:0]              humidity_data_out,
    input  logic [15:0]              dew_data_out,
    input  logic [15:0]              moisture_data_out,
    input  logic [15:0]              water_lvl_data_out,
    input  logic                     evt_pop,
    input  logic                     ovf_clr,
    output logic                     evt_valid,
    output logic [2:0]               evt_id,
    output logic [15:0]              evt_data,
    output logic [$clog2(DEPTH):0]   evt_count,
    output logic                     evt_irq,
    output logic                     evt_overflow,
    output logic [7:0]               evt_ovf_cnt
);
    localparam int NS = 5;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [NS-1:0] w_flag;
    logic [15:0]   w_din [NS];
    logic [NS-1:0] r_flag_q;
    logic [NS-1:0] w_edge;
    logic [NS-1:0] r_pending;
    logic [15:0]   r_hold [NS];
    logic [2:0]    r_last;

    logic          w_gnt_any;
    logic [2:0]    w_gnt_id;
    logic [3:0]    w_sum;
    logic [2:0]    w_sel;
    logic          w_push;
    logic          w_pop;
    logic [NS-1:0] w_loss;

    logic [18:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_nxt;
    logic [18:0]   w_head;
    logic          r_irq;
    logic          r_ovf;

    assign w_flag = {water_lvl_thrhold_reached, moisture_thrhold_reached,
                     dew_thrhold_reached, humidity_thrhold_reached, temp_thrhold_reached};
    assign w_din[0] = temp_data_out;
    assign w_din[1] = humidity_data_out;
    assign w_din[2] = dew_data_out;
    assign w_din[3] = moisture_data_out;
    assign w_din[4] = water_lvl_data_out;

    assign w_edge = w_flag & ~r_flag_q;

    // Rotating search starting one past the last granted sensor.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_id  = '0;
        w_sum     = '0;
        w_sel     = '0;
        for (int k = 0; k < NS; k++) begin
            w_sum = {1'b0, r_last} + 4'd1 + 4'(k);
            if (w_sum >= 4'd5) begin
                w_sum = w_sum - 4'd5;
            end
            w_sel = w_sum[2:0];
            if (!w_gnt_any && r_pending[w_sel]) begin
                w_gnt_any = 1'b1;
                w_gnt_id  = w_sel;
            end
        end
    end

    assign w_push = w_gnt_any && (r_count != CW'(DEPTH));
    assign w_pop  = evt_pop && (r_count != '0);

    // A same-cycle grant consumes the older event, so the new edge is not a loss.
    always_comb begin
        w_loss = '0;
        for (int i = 0; i < NS; i++) begin
            w_loss[i] = w_edge[i] && r_pending[i] && !(w_push && (w_gnt_id == 3'(i)));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flag_q  <= '0;
            r_pending <= '0;
            r_last    <= 3'd4;
            for (int i = 0; i < NS; i++) begin
                r_hold[i] <= '0;
            end
        end else begin
            r_flag_q <= w_flag;
            if (w_push) begin
                r_last <= w_gnt_id;
            end
            for (int i = 0; i < NS; i++) begin
                if (w_edge[i]) begin
                    r_pending[i] <= 1'b1;
                    r_hold[i]    <= w_din[i];
                end else if (w_push && (w_gnt_id == 3'(i))) begin
                    r_pending[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_gnt_id, r_hold[w_gnt_id]};
        end
    end

    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_irq    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_nxt;
            r_irq   <= (w_count_nxt >= CW'(IRQ_LEVEL));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ovf <= 1'b0;
        end else if (ovf_clr) begin
            r_ovf <= |w_loss;
        end else if (|w_loss) begin
            r_ovf <= 1'b1;
        end
    end

`ifdef SENSOR_EVT_OVF_CNT_EN
    logic [2:0] w_loss_n;
    logic [8:0] w_cnt_sum;
    logic [7:0] r_ovf_cnt;

    always_comb begin
        w_loss_n = '0;
        for (int i = 0; i < NS; i++) begin
            w_loss_n = w_loss_n + 3'(w_loss[i]);
        end
        w_cnt_sum = 9'(r_ovf_cnt) + 9'(w_loss_n);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ovf_cnt <= '0;
        end else if (ovf_clr) begin
            r_ovf_cnt <= 8'(w_loss_n);
        end else if (w_loss_n != 3'd0) begin
            r_ovf_cnt <= w_cnt_sum[8] ? 8'hFF : w_cnt_sum[7:0];
        end
    end

    assign evt_ovf_cnt = r_ovf_cnt;
`else
    assign evt_ovf_cnt = '0;
`endif

    assign w_head       = r_mem[r_rd_ptr];
    assign evt_valid    = (r_count != '0);
    assign evt_id       = evt_valid ? w_head[18:16] : 3'd0;
    assign evt_data     = evt_valid ? w_head[15:0] : 16'd0;
    assign evt_count    = r_count;
    assign evt_irq      = r_irq;
    assign evt_overflow = r_ovf;

endmodule

// File: tb/tb_sensor_event_queue.sv
// Bench for sensor_event_queue: table of edge bursts with hand-derived grant order, plus corner-case sequences.
`timescale 1ns/1ps
module tb_sensor_event_queue;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  flags;
    logic [15:0] din [5];
    logic        evt_pop;
    logic        ovf_clr;
    logic        evt_valid;
    logic [2:0]  evt_id;
    logic [15:0] evt_data;
    logic [3:0]  evt_count;
    logic        evt_irq;
    logic        evt_overflow;
    logic [7:0]  evt_ovf_cnt;

    always #5 clk = ~clk;

    sensor_event_queue #(.DEPTH(DEPTH), .IRQ_LEVEL(1)) dut (
        .clk                       (clk),
        .reset                     (reset),
        .temp_thrhold_reached      (flags[0]),
        .humidity_thrhold_reached  (flags[1]),
        .dew_thrhold_reached       (flags[2]),
        .moisture_thrhold_reached  (flags[3]),
        .water_lvl_thrhold_reached (flags[4]),
        .temp_data_out             (din[0]),
        .humidity_data_out         (din[1]),
        .dew_data_out              (din[2]),
        .moisture_data_out         (din[3]),
        .water_lvl_data_out        (din[4]),
        .evt_pop                   (evt_pop),
        .ovf_clr                   (ovf_clr),
        .evt_valid                 (evt_valid),
        .evt_id                    (evt_id),
        .evt_data                  (evt_data),
        .evt_count                 (evt_count),
        .evt_irq                   (evt_irq),
        .evt_overflow              (evt_overflow),
        .evt_ovf_cnt               (evt_ovf_cnt)
    );

    typedef struct {
        logic [4:0]  mask;
        logic [15:0] base;
        int          n;
        logic [2:0]  ord [5];
    } vec_t;

    vec_t        tbl [7];
    logic [18:0] sb [$];
    int          n_chk = 0;
    int          n_err = 0;
    logic [7:0]  exp_ovf_cnt;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Flags in mask go high for one cycle; sensor i presents base+i.
    task automatic pulse(input logic [4:0] m, input logic [15:0] base);
        for (int i = 0; i < 5; i++) begin
            if (m[i]) din[i] = base + 16'(i);
        end
        flags = m;
        @(negedge clk);
        flags = '0;
    endtask

    task automatic pop_check(input string nm);
        logic [18:0] e;
        check({nm, "_valid"}, 32'(evt_valid), 32'd1);
        if (sb.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL %s_sb: got empty scoreboard expected an entry", nm);
        end else begin
            e = sb.pop_front();
            check({nm, "_id"}, 32'(evt_id), 32'(e[18:16]));
            check({nm, "_data"}, 32'(evt_data), 32'(e[15:0]));
        end
        evt_pop = 1'b1;
        @(negedge clk);
        evt_pop = 1'b0;
    endtask

    task automatic set_row(input int r, input logic [4:0] m, input logic [15:0] b, input int n,
                           input logic [2:0] o0, input logic [2:0] o1, input logic [2:0] o2,
                           input logic [2:0] o3, input logic [2:0] o4);
        tbl[r].mask   = m;
        tbl[r].base   = b;
        tbl[r].n      = n;
        tbl[r].ord[0] = o0;
        tbl[r].ord[1] = o1;
        tbl[r].ord[2] = o2;
        tbl[r].ord[3] = o3;
        tbl[r].ord[4] = o4;
    endtask

    initial begin
`ifdef SENSOR_EVT_OVF_CNT_EN
        exp_ovf_cnt = 8'd1;
`else
        exp_ovf_cnt = 8'd0;
`endif
        // Grant orders follow the round-robin pointer as it carries from row to row.
        set_row(0, 5'b11111, 16'h00A0, 5, 0, 1, 2, 3, 4);
        set_row(1, 5'b00010, 16'h0B00, 1, 1, 0, 0, 0, 0);
        set_row(2, 5'b00101, 16'h0C00, 2, 2, 0, 0, 0, 0);
        set_row(3, 5'b11000, 16'h0D00, 2, 3, 4, 0, 0, 0);
        set_row(4, 5'b10001, 16'h0E00, 2, 0, 4, 0, 0, 0);
        set_row(5, 5'b01110, 16'h0F00, 3, 1, 2, 3, 0, 0);
        set_row(6, 5'b10101, 16'h1000, 3, 4, 0, 2, 0, 0);

        reset = 1'b0; flags = '0; evt_pop = 1'b0; ovf_clr = 1'b0;
        for (int i = 0; i < 5; i++) din[i] = '0;
        tick(2);
        reset = 1'b1;
        tick(1);
        check("rst_valid", 32'(evt_valid), 0);
        check("rst_id", 32'(evt_id), 0);
        check("rst_data", 32'(evt_data), 0);
        check("rst_count", 32'(evt_count), 0);
        check("rst_irq", 32'(evt_irq), 0);
        check("rst_ovf", 32'(evt_overflow), 0);
        check("rst_ovf_cnt", 32'(evt_ovf_cnt), 0);

        // Single event: two-edge latency, then pop to empty.
        din[0] = 16'h1234; flags[0] = 1'b1;
        tick(1);
        check("single_lat_valid", 32'(evt_valid), 0);
        tick(1);
        check("single_valid", 32'(evt_valid), 1);
        check("single_id", 32'(evt_id), 0);
        check("single_data", 32'(evt_data), 32'h1234);
        check("single_count", 32'(evt_count), 1);
        check("single_irq", 32'(evt_irq), 1);
        flags[0] = 1'b0;
        evt_pop = 1'b1;
        tick(1);
        evt_pop = 1'b0;
        check("single_pop_valid", 32'(evt_valid), 0);
        check("single_pop_count", 32'(evt_count), 0);
        check("single_pop_irq", 32'(evt_irq), 0);

        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        tick(1);

        for (int r = 0; r < 7; r++) begin
            pulse(tbl[r].mask, tbl[r].base);
            for (int k = 0; k < tbl[r].n; k++) begin
                sb.push_back({tbl[r].ord[k], 16'(tbl[r].base + 16'(tbl[r].ord[k]))});
            end
            tick(6);
            check($sformatf("row%0d_count", r), 32'(evt_count), 32'(tbl[r].n));
            check($sformatf("row%0d_irq", r), 32'(evt_irq), 1);
            for (int k = 0; k < tbl[r].n; k++) begin
                pop_check($sformatf("row%0d_pop%0d", r, k));
            end
            check($sformatf("row%0d_empty", r), 32'(evt_valid), 0);
        end

        // Fill to DEPTH, then two humidity edges while it is held pending.
        for (int j = 0; j < DEPTH; j++) begin
            pulse(5'b00001, 16'h5000 + 16'(j));
            sb.push_back({3'd0, 16'h5000 + 16'(j)});
            tick(1);
        end
        tick(3);
        check("full_count", 32'(evt_count), DEPTH);
        check("full_irq", 32'(evt_irq), 1);
        pulse(5'b00010, 16'h7000);
        tick(1);
        pulse(5'b00010, 16'h7001);
        tick(2);
        check("full_hold_count", 32'(evt_count), DEPTH);
        check("ovf_flag", 32'(evt_overflow), 1);
        check("ovf_cnt", 32'(evt_ovf_cnt), 32'(exp_ovf_cnt));
        sb.push_back({3'd1, 16'h7002});
        pop_check("full_pop");
        tick(2);
        check("refill_count", 32'(evt_count), DEPTH);
        check("ovf_sticky", 32'(evt_overflow), 1);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        check("ovf_clr_flag", 32'(evt_overflow), 0);
        check("ovf_clr_cnt", 32'(evt_ovf_cnt), 0);
        for (int k = 0; k < DEPTH; k++) pop_check($sformatf("full_drain%0d", k));
        check("full_drain_empty", 32'(evt_valid), 0);

        // Push and pop on the same edge at count 3.
        for (int j = 0; j < 3; j++) begin
            pulse(5'b00001, 16'h6000 + 16'(j));
            sb.push_back({3'd0, 16'h6000 + 16'(j)});
            tick(1);
        end
        tick(2);
        check("pp_count_pre", 32'(evt_count), 3);
        din[0] = 16'h6003; flags[0] = 1'b1;
        tick(1);
        check("pp_head_id", 32'(evt_id), 0);
        check("pp_head_data", 32'(evt_data), 32'(sb[0][15:0]));
        void'(sb.pop_front());
        sb.push_back({3'd0, 16'h6003});
        flags[0] = 1'b0;
        evt_pop = 1'b1;
        tick(1);
        evt_pop = 1'b0;
        check("pp_count_same", 32'(evt_count), 3);
        tick(1);
        check("pp_count_after", 32'(evt_count), 3);
        for (int k = 0; k < 3; k++) pop_check($sformatf("pp_drain%0d", k));

        // Pop on empty must not move the read pointer.
        evt_pop = 1'b1;
        tick(1);
        evt_pop = 1'b0;
        check("empty_pop_count", 32'(evt_count), 0);
        check("empty_pop_valid", 32'(evt_valid), 0);
        pulse(5'b01000, 16'h4400);
        sb.push_back({3'd3, 16'h4403});
        tick(3);
        pop_check("after_empty_pop");

        // Asynchronous reset in the middle of a drain.
        pulse(5'b11111, 16'h9000);
        tick(6);
        check("mid_count", 32'(evt_count), 5);
        evt_pop = 1'b1;
        tick(2);
        #2 reset = 1'b0;
        #1;
        check("arst_valid", 32'(evt_valid), 0);
        check("arst_id", 32'(evt_id), 0);
        check("arst_data", 32'(evt_data), 0);
        check("arst_count", 32'(evt_count), 0);
        check("arst_irq", 32'(evt_irq), 0);
        check("arst_ovf", 32'(evt_overflow), 0);
        check("arst_ovf_cnt", 32'(evt_ovf_cnt), 0);
        sb.delete();
        evt_pop = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        tick(2);
        check("post_rst_valid", 32'(evt_valid), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/sensor_event_queue.md
# sensor_event_queue

Downstream consumer of the sensor threshold controller. Detects rising edges on the five per-sensor threshold-reached flags and captures the accompanying 16-bit sensor data. Queues one event per edge in a first-word-fall-through FIFO with round-robin arbitration between sensors. Presents the queue head, fill level, interrupt and overflow status to the host-side logic.

## Interface
Parameters:
- DEPTH, 8, FIFO entries; power of two, ≥ 2
- IRQ_LEVEL, 1, evt_irq asserts when evt_count ≥ IRQ_LEVEL; range 1..DEPTH

Ports:
- clk  in  1  system clock; single clock domain
- reset  in  1  asynchronous, active-low reset
- temp_thrhold_reached, humidity_thrhold_reached, dew_thrhold_reached, moisture_thrhold_reached, water_lvl_thrhold_reached  in  1 each  level flags from the threshold controller
- temp_data_out, humidity_data_out, dew_data_out, moisture_data_out, water_lvl_data_out  in  16 each  sensor data paired with each flag
- evt_pop  in  1  consume the head entry
- ovf_clr  in  1  clear evt_overflow and evt_ovf_cnt
- evt_valid  out  1  FIFO non-empty
- evt_id  out  3  head sensor ID: 0 temp, 1 humidity, 2 dew, 3 moisture, 4 water level
- evt_data  out  16  head data
- evt_count  out  $clog2(DEPTH)+1  entries held
- evt_irq  out  1  registered fill-level interrupt
- evt_overflow  out  1  sticky event-lost flag
- evt_ovf_cnt  out  8  saturating lost-event count; see Configuration

## Operation
- Edge detect: per-sensor registered copy of the flag. Reset value is 0, so a flag that is high out of reset counts as a rising edge.
- Rising edge on sensor i:
  - sets pending[i]
  - loads hold_data[i] with that sensor's data_out in the same cycle
- Rising edge while pending[i] is already set:
  - hold_data[i] is overwritten with the newer data
  - the older event is lost: evt_overflow sets and evt_ovf_cnt increments, saturating at 255
- Arbiter: round-robin over the pending bits, starting at (last_grant+1) mod 5. last_grant resets to 4, so sensor 0 has first priority.
- Push: one grant per cycle, and only when the registered evt_count < DEPTH. The push writes {i, hold_data[i]}, clears pending[i] and updates last_grant.
- Full FIFO: no grant. Pending bits are held; further edges on a held sensor follow the overflow rule above.
- Same-cycle edge and grant on the same sensor: the grant takes the current hold_data, and the new edge re-sets pending[i] with the new data. No overflow is counted.
- Pop: evt_pop && evt_valid advances the read pointer. A pop on empty is ignored.
- Push and pop in the same cycle: both happen and evt_count is unchanged. Push eligibility is still judged on the pre-pop count.
- Pointers wrap modulo DEPTH. evt_count ranges 0..DEPTH.
- ovf_clr clears evt_overflow and evt_ovf_cnt. When ovf_clr coincides with a new loss, the result is evt_overflow = 1 and evt_ovf_cnt = 1.

## Timing
- Reset values: evt_valid 0, evt_id 0, evt_data 0, evt_count 0, evt_irq 0, evt_overflow 0, evt_ovf_cnt 0. Pending bits, edge registers, pointers and last_grant also reset; last_grant resets to 4.
- Latency: flag first sampled high at edge k → pending set after edge k → pushed at edge k+1 → evt_valid/evt_id/evt_data visible after edge k+1.
- FWFT: the head is valid combinationally from the registered RAM and pointer. A pop at edge n presents the next entry after edge n.
- evt_irq is registered from the next-state evt_count, so it tracks evt_count with zero added cycles.
- Throughput: one push and one pop per cycle.
- Five simultaneous edges drain one per cycle, in order 0,1,2,3,4 from reset.

## Configuration
- SENSOR_EVT_OVF_CNT_EN
  - Defined: evt_ovf_cnt is an 8-bit saturating counter as described.
  - Undefined: the counter logic is removed and evt_ovf_cnt is tied to 0.
- evt_overflow is present in both builds.

## Test plan
- Single event: reset released, temp flag rises with data 0x1234 → after 2 cycles evt_valid=1, evt_id=0, evt_data=0x1234, evt_count=1, evt_irq=1. Pop → evt_valid=0 and evt_count=0 next cycle.
- Simultaneous edges: all five flags rise together with data 0xA0..0xA4 → five pushes on consecutive cycles, popped IDs 0,1,2,3,4 with matching data.
- Round-robin fairness: sensor 1 granted, then sensors 0 and 2 edge together → sensor 2 is granted before sensor 0.
- Full and overflow: DEPTH=8, 8 events with no pops, then humidity edges twice → evt_count=8, pending held, evt_overflow=1, evt_ovf_cnt=1. One pop → the latest humidity data is pushed. ovf_clr → both cleared.
- Push/pop same cycle at count 3 → evt_count stays 3. Pop on empty → no change. Reset asserted mid-drain → all outputs return to reset values asynchronously.
- Build without SENSOR_EVT_OVF_CNT_EN: the overflow scenario above gives evt_ovf_cnt=0 and evt_overflow=1.
